// File: rtl/flight_loop_scheduler_pkg.sv
// Shared types for the flight loop scheduler: one-hot state encoding, fault stage
// codes and the saturating statistics counter width.
package flight_loop_scheduler_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int SAT_W = 8;
    localparam logic [SAT_W-1:0] SAT_ZERO = '0;
    localparam logic [SAT_W-1:0] SAT_MAX  = '1;

    typedef enum logic [5:0] {
        ST_IDLE       = 6'b000001,
        ST_WAIT_TICK  = 6'b000010,
        ST_ANGLE_WAIT = 6'b000100,
        ST_RATE_WAIT  = 6'b001000,
        ST_MIX_WAIT   = 6'b010000,
        ST_FAULT      = 6'b100000
    } state_e;

    typedef enum logic [1:0] {
        FS_NONE  = 2'b00,
        FS_ANGLE = 2'b01,
        FS_RATE  = 2'b10,
        FS_MIXER = 2'b11
    } fault_stage_e;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
        return (v == SAT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic is_wait(input state_e s);
        return (s == ST_ANGLE_WAIT) || (s == ST_RATE_WAIT) || (s == ST_MIX_WAIT);
    endfunction

endpackage

// File: rtl/flight_loop_scheduler_loop_period_timer.sv
// Loop period counter: counts while enabled, is cleared by clear_i, and flags the
// last cycle of each period with tick_o before wrapping to zero.
module flight_loop_scheduler_loop_period_timer #(
    parameter int PERIOD = 2500,
    parameter int CNT_W  = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_end;

    assign at_end = (count_q == CNT_W'(PERIOD - 1));
    assign tick_o = en_i && !clear_i && at_end;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = at_end ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flight_loop_scheduler.sv
// Fixed-rate angle -> rate -> mixer sequencer with per-stage watchdog.
// Optional loop timing statistics are built when LOOP_STATS_EN is defined.
module flight_loop_scheduler
    import flight_loop_scheduler_pkg::*;
#(
    parameter int LOOP_PERIOD_US   = 2500,
    parameter int STAGE_TIMEOUT_US = 200,
    parameter int CNT_W            = 16
) (
    input  logic             us_clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             imu_data_valid_i,
    input  logic             angle_complete_i,
    input  logic             rate_complete_i,
    input  logic             mixer_complete_i,
    output logic             angle_start_o,
    output logic             rate_start_o,
    output logic             mixer_start_o,
    output logic             busy_o,
    output logic             motors_safe_o,
    output logic             fault_o,
    output logic [1:0]       fault_stage_o,
    output logic [SAT_W-1:0] overrun_count_o,
    output logic [SAT_W-1:0] skip_count_o,
`ifdef LOOP_STATS_EN
    output logic [CNT_W-1:0] last_loop_cycles_o,
    output logic [CNT_W-1:0] max_loop_cycles_o,
`endif
    output logic [5:0]       state_o
);

    state_e           state_q, state_d;
    logic             tick;
    logic             in_wait;
    logic             stage_timeout;

    logic [CNT_W-1:0] stage_timer_q, stage_timer_d;
    logic             angle_start_q, angle_start_d;
    logic             rate_start_q, rate_start_d;
    logic             mixer_start_q, mixer_start_d;
    logic             busy_q, busy_d;
    logic             motors_safe_q, motors_safe_d;
    logic             fault_q, fault_d;
    fault_stage_e     fault_stage_q, fault_stage_d;
    logic [SAT_W-1:0] overrun_q, overrun_d;
    logic [SAT_W-1:0] skip_q, skip_d;

    flight_loop_scheduler_loop_period_timer #(
        .PERIOD (LOOP_PERIOD_US),
        .CNT_W  (CNT_W)
    ) u_loop_period_timer (
        .clk_i   (us_clk_i),
        .reset_i (reset_i),
        .clear_i (!enable_i),
        .en_i    (enable_i && (state_q != ST_FAULT)),
        .tick_o  (tick)
    );

    assign in_wait       = is_wait(state_q);
    assign stage_timeout = in_wait && (stage_timer_q == CNT_W'(STAGE_TIMEOUT_US - 1));

    always_ff @(posedge us_clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A complete arriving together with the timeout takes priority over the fault.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
                if (!enable_i)                      state_d = ST_IDLE;
                else if (tick && imu_data_valid_i)  state_d = ST_ANGLE_WAIT;
            end
            ST_ANGLE_WAIT: begin
                if (!enable_i)             state_d = ST_IDLE;
                else if (angle_complete_i) state_d = ST_RATE_WAIT;
                else if (stage_timeout)    state_d = ST_FAULT;
            end
            ST_RATE_WAIT: begin
                if (!enable_i)            state_d = ST_IDLE;
                else if (rate_complete_i) state_d = ST_MIX_WAIT;
                else if (stage_timeout)   state_d = ST_FAULT;
            end
            ST_MIX_WAIT: begin
                if (!enable_i)             state_d = ST_IDLE;
                else if (mixer_complete_i) state_d = ST_WAIT_TICK;
                else if (stage_timeout)    state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (!enable_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        angle_start_d = (state_q == ST_WAIT_TICK)  && (state_d == ST_ANGLE_WAIT);
        rate_start_d  = (state_q == ST_ANGLE_WAIT) && (state_d == ST_RATE_WAIT);
        mixer_start_d = (state_q == ST_RATE_WAIT)  && (state_d == ST_MIX_WAIT);
        busy_d        = is_wait(state_d);
        motors_safe_d = ((state_d == ST_IDLE) || (state_d == ST_FAULT)) ? TRUE : FALSE;
        fault_d       = (state_d == ST_FAULT) ? TRUE : FALSE;

        fault_stage_d = fault_stage_q;
        if (state_d != ST_FAULT) begin
            fault_stage_d = FS_NONE;
        end else if (state_q != ST_FAULT) begin
            case (state_q)
                ST_ANGLE_WAIT: fault_stage_d = FS_ANGLE;
                ST_RATE_WAIT:  fault_stage_d = FS_RATE;
                ST_MIX_WAIT:   fault_stage_d = FS_MIXER;
                default:       fault_stage_d = FS_NONE;
            endcase
        end

        stage_timer_d = stage_timer_q;
        if (angle_start_d || rate_start_d || mixer_start_d) begin
            stage_timer_d = '0;
        end else if (in_wait) begin
            stage_timer_d = stage_timer_q + CNT_W'(1);
        end

        // Ticks that land mid-loop are counted and discarded, never queued.
        overrun_d = (tick && in_wait) ? sat_inc(overrun_q) : overrun_q;
        skip_d    = (tick && (state_q == ST_WAIT_TICK) && !imu_data_valid_i)
                    ? sat_inc(skip_q) : skip_q;
    end

    always_ff @(posedge us_clk_i) begin
        if (reset_i) begin
            stage_timer_q <= '0;
            angle_start_q <= FALSE;
            rate_start_q  <= FALSE;
            mixer_start_q <= FALSE;
            busy_q        <= FALSE;
            motors_safe_q <= TRUE;
            fault_q       <= FALSE;
            fault_stage_q <= FS_NONE;
            overrun_q     <= SAT_ZERO;
            skip_q        <= SAT_ZERO;
        end else begin
            stage_timer_q <= stage_timer_d;
            angle_start_q <= angle_start_d;
            rate_start_q  <= rate_start_d;
            mixer_start_q <= mixer_start_d;
            busy_q        <= busy_d;
            motors_safe_q <= motors_safe_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
            overrun_q     <= overrun_d;
            skip_q        <= skip_d;
        end
    end

`ifdef LOOP_STATS_EN
    logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d;
    logic [CNT_W-1:0] last_loop_q, last_loop_d;
    logic [CNT_W-1:0] max_loop_q, max_loop_d;
    logic             loop_done;

    // loop_cnt_q is 1 in the angle_start cycle, so it already includes the complete cycle.
    assign loop_done = (state_q == ST_MIX_WAIT) && (state_d == ST_WAIT_TICK);

    always_comb begin
        loop_cnt_d = loop_cnt_q;
        if (angle_start_d) begin
            loop_cnt_d = CNT_W'(1);
        end else if (in_wait) begin
            loop_cnt_d = loop_cnt_q + CNT_W'(1);
        end
        last_loop_d = loop_done ? loop_cnt_q : last_loop_q;
        max_loop_d  = (loop_done && (loop_cnt_q > max_loop_q)) ? loop_cnt_q : max_loop_q;
    end

    always_ff @(posedge us_clk_i) begin
        if (reset_i) begin
            loop_cnt_q  <= '0;
            last_loop_q <= '0;
            max_loop_q  <= '0;
        end else begin
            loop_cnt_q  <= loop_cnt_d;
            last_loop_q <= last_loop_d;
            max_loop_q  <= max_loop_d;
        end
    end

    assign last_loop_cycles_o = last_loop_q;
    assign max_loop_cycles_o  = max_loop_q;
`endif

    assign angle_start_o   = angle_start_q;
    assign rate_start_o    = rate_start_q;
    assign mixer_start_o   = mixer_start_q;
    assign busy_o          = busy_q;
    assign motors_safe_o   = motors_safe_q;
    assign fault_o         = fault_q;
    assign fault_stage_o   = fault_stage_q;
    assign overrun_count_o = overrun_q;
    assign skip_count_o    = skip_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_flight_loop_scheduler.sv
// Directed bench for flight_loop_scheduler with a 20-cycle loop and 8-cycle stage timeout.
module tb_flight_loop_scheduler;

    localparam int LOOP_P = 20;
    localparam int TMO    = 8;
    localparam int CW     = 16;

    localparam logic [5:0] S_IDLE  = 6'b000001;
    localparam logic [5:0] S_WTICK = 6'b000010;
    localparam logic [5:0] S_RATE  = 6'b001000;
    localparam logic [5:0] S_FAULT = 6'b100000;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       imu_valid;
    logic       angle_cmp, rate_cmp, mixer_cmp;
    logic       angle_start, rate_start, mixer_start;
    logic       busy, motors_safe, fault;
    logic [1:0] fault_stage;
    logic [7:0] overrun_count, skip_count;
    logic [5:0] state;
`ifdef LOOP_STATS_EN
    logic [CW-1:0] last_loop, max_loop;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    flight_loop_scheduler #(
        .LOOP_PERIOD_US   (LOOP_P),
        .STAGE_TIMEOUT_US (TMO),
        .CNT_W            (CW)
    ) dut (
        .us_clk_i           (clk),
        .reset_i            (reset),
        .enable_i           (enable),
        .imu_data_valid_i   (imu_valid),
        .angle_complete_i   (angle_cmp),
        .rate_complete_i    (rate_cmp),
        .mixer_complete_i   (mixer_cmp),
        .angle_start_o      (angle_start),
        .rate_start_o       (rate_start),
        .mixer_start_o      (mixer_start),
        .busy_o             (busy),
        .motors_safe_o      (motors_safe),
        .fault_o            (fault),
        .fault_stage_o      (fault_stage),
        .overrun_count_o    (overrun_count),
        .skip_count_o       (skip_count),
`ifdef LOOP_STATS_EN
        .last_loop_cycles_o (last_loop),
        .max_loop_cycles_o  (max_loop),
`endif
        .state_o            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic start_of(input int which);
        case (which)
            0:       return angle_start;
            1:       return rate_start;
            default: return mixer_start;
        endcase
    endfunction

    task automatic drive_complete(input int which, input logic v);
        case (which)
            0:       angle_cmp = v;
            1:       rate_cmp  = v;
            default: mixer_cmp = v;
        endcase
    endtask

    task automatic wait_start(input int which, output int at);
        logic found;
        found = 1'b0;
        at    = -1;
        for (int n = 0; n < 60 && !found; n++) begin
            if (start_of(which) === 1'b1) begin
                found = 1'b1;
                at    = cyc;
            end else begin
                step(1);
            end
        end
        check($sformatf("start%0d_seen", which), {31'd0, found}, 32'd1);
    endtask

    // Complete is high during the cycle lat cycles after the start pulse.
    task automatic pulse_complete(input int which, input int lat);
        step(1);
        check($sformatf("start%0d_one_cycle", which), {31'd0, start_of(which)}, 32'd0);
        step(lat - 1);
        drive_complete(which, 1'b1);
        step(1);
        drive_complete(which, 1'b0);
    endtask

    task automatic serve(input int which, input int lat, output int at);
        wait_start(which, at);
        if (at >= 0) pulse_complete(which, lat);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        angle_cmp = 1'b0;
        rate_cmp  = 1'b0;
        mixer_cmp = 1'b0;
        step(2);
        check("rst_state", {26'd0, state}, {26'd0, S_IDLE});
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_motors_safe", {31'd0, motors_safe}, 32'd1);
        check("rst_overrun", {24'd0, overrun_count}, 32'd0);
        reset = 1'b0;
    endtask

    int c0, t_a, t_r, t_m, t_x;

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        imu_valid = 1'b0;
        angle_cmp = 1'b0;
        rate_cmp  = 1'b0;
        mixer_cmp = 1'b0;

        // Test 1: nominal loop, completes 2 cycles after each start
        do_reset();
        check("rst_angle_start", {31'd0, angle_start}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_fault_stage", {30'd0, fault_stage}, 32'd0);
        check("rst_skip", {24'd0, skip_count}, 32'd0);
        imu_valid = 1'b1;
        enable    = 1'b1;
        c0        = cyc;
        step(1);
        check("t1_wait_tick", {26'd0, state}, {26'd0, S_WTICK});
        check("t1_motors_safe_low", {31'd0, motors_safe}, 32'd0);
        serve(0, 2, t_a);
        check("t1_angle_at_20", t_a - c0, 32'd20);
        serve(1, 2, t_r);
        check("t1_rate_gap", t_r - t_a, 32'd3);
        wait_start(2, t_m);
        check("t1_mixer_gap", t_m - t_r, 32'd3);
        check("t1_busy_in_loop", {31'd0, busy}, 32'd1);
        pulse_complete(2, 2);
        check("t1_busy_fall_cycle", cyc - c0, 32'd29);
        check("t1_busy_low", {31'd0, busy}, 32'd0);
        check("t1_motors_safe", {31'd0, motors_safe}, 32'd0);

        // Test 2: IMU invalid at the first tick
        do_reset();
        imu_valid = 1'b0;
        enable    = 1'b1;
        c0        = cyc;
        step(20);
        check("t2_no_angle", {31'd0, angle_start}, 32'd0);
        check("t2_skip_one", {24'd0, skip_count}, 32'd1);
        imu_valid = 1'b1;
        serve(0, 1, t_a);
        check("t2_angle_at_40", t_a - c0, 32'd40);
        serve(1, 1, t_r);
        serve(2, 1, t_m);
        check("t2_busy_low", {31'd0, busy}, 32'd0);
        check("t2_skip_still_one", {24'd0, skip_count}, 32'd1);

        // Test 3: rate stage times out
        do_reset();
        enable = 1'b1;
        serve(0, 2, t_a);
        wait_start(1, t_r);
        step(7);
        check("t3_no_fault_yet", {31'd0, fault}, 32'd0);
        check("t3_rate_wait", {26'd0, state}, {26'd0, S_RATE});
        step(1);
        check("t3_fault", {31'd0, fault}, 32'd1);
        check("t3_fault_stage", {30'd0, fault_stage}, 32'd2);
        check("t3_motors_safe", {31'd0, motors_safe}, 32'd1);
        check("t3_busy_low", {31'd0, busy}, 32'd0);
        check("t3_no_mixer", {31'd0, mixer_start}, 32'd0);
        step(25);
        check("t3_fault_held", {26'd0, state}, {26'd0, S_FAULT});
        check("t3_fault_sticky", {31'd0, fault}, 32'd1);
        enable = 1'b0;
        step(1);
        check("t3_idle", {26'd0, state}, {26'd0, S_IDLE});
        check("t3_fault_clear", {31'd0, fault}, 32'd0);
        check("t3_stage_clear", {30'd0, fault_stage}, 32'd0);
        enable = 1'b1;
        step(1);
        check("t3_rearm", {26'd0, state}, {26'd0, S_WTICK});
        check("t3_rearm_safe", {31'd0, motors_safe}, 32'd0);

        // Test 4: complete coincides with timeout on every stage
        do_reset();
        enable = 1'b1;
        c0     = cyc;
        serve(0, 7, t_a);
        serve(1, 7, t_r);
        check("t4_rate_gap", t_r - t_a, 32'd8);
        check("t4_no_fault_a", {31'd0, fault}, 32'd0);
        serve(2, 7, t_m);
        check("t4_mixer_gap", t_m - t_r, 32'd8);
        check("t4_busy_low", {31'd0, busy}, 32'd0);
        check("t4_no_fault", {31'd0, fault}, 32'd0);
        check("t4_overrun", {24'd0, overrun_count}, 32'd1);
        wait_start(0, t_x);
        check("t4_next_angle_60", t_x - c0, 32'd60);

        // Test 5: reset mid-loop, then enable dropped during RATE_WAIT
        do_reset();
        check("t5_rst_overrun", {24'd0, overrun_count}, 32'd0);
        enable = 1'b1;
        serve(0, 2, t_a);
        wait_start(1, t_r);
        step(1);
        enable = 1'b0;
        step(1);
        check("t5_idle", {26'd0, state}, {26'd0, S_IDLE});
        check("t5_busy_low", {31'd0, busy}, 32'd0);
        check("t5_motors_safe", {31'd0, motors_safe}, 32'd1);
        rate_cmp = 1'b1;
        enable   = 1'b1;
        step(1);
        rate_cmp = 1'b0;
        check("t5_late_ignored", {31'd0, mixer_start}, 32'd0);
        check("t5_wait_tick", {26'd0, state}, {26'd0, S_WTICK});
        step(1);
        check("t5_late_ignored2", {31'd0, mixer_start}, 32'd0);

`ifdef LOOP_STATS_EN
        // Test 6a: loop statistics
        do_reset();
        enable = 1'b1;
        serve(0, 2, t_a);
        serve(1, 3, t_r);
        serve(2, 4, t_m);
        check("t6_last_12", {16'd0, last_loop}, 32'd12);
        check("t6_max_12", {16'd0, max_loop}, 32'd12);
        serve(0, 1, t_a);
        serve(1, 1, t_r);
        serve(2, 1, t_m);
        check("t6_last_6", {16'd0, last_loop}, 32'd6);
        check("t6_max_kept", {16'd0, max_loop}, 32'd12);
`endif

        // Test 6b: overrun counter saturation
        do_reset();
        enable = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            serve(0, 7, t_a);
            serve(1, 7, t_r);
            serve(2, 7, t_m);
            if (i == 100) check("t6_overrun_100", {24'd0, overrun_count}, 32'd100);
        end
        check("t6_overrun_sat", {24'd0, overrun_count}, 32'd255);
        check("t6_no_fault", {31'd0, fault}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
